mem_arb: RTL and testbench

- Arbiter/sequencer for the single shared unified memory of the multicycle CPU.
- Shares the memory between the CPU port (the instruction/data path selected by IorD) and a DMA/loader port.
- Serialises accesses, inserts the memory's wait states and returns read data with a one-cycle ack pulse, so the control FSM can stall on a missing ack.

---
 rtl/mem_arb_pkg.sv | 21 ++
 rtl/mem_arb_pick.sv | 45 ++++
 rtl/mem_arb.sv | 171 +++++++++++++++++
 tb/tb_mem_arb.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the unified-memory arbiter: FSM state and one-hot owner encoding.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Owner encoding doubles as the grant output value.
    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_CPU  = 2'b01,
        OWN_DMA  = 2'b10
    } owner_t;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selection between the CPU and DMA ports.
// MEM_ARB_RR_EN selects round-robin; otherwise fixed CPU priority with a DMA starvation override.
module arb_pick
    import mem_arb_pkg::*;
`ifdef MEM_ARB_RR_EN
(
    input  logic   cpu_req,
    input  logic   dma_req,
    input  logic   last_dma,
    output owner_t winner
);
`else
#(
    parameter int STARVE_LIMIT = 4,
    parameter int SW           = 3
) (
    input  logic          cpu_req,
    input  logic          dma_req,
    input  logic [SW-1:0] starve,
    output owner_t        winner
);
`endif

    always_comb begin
        winner = OWN_NONE;
`ifdef MEM_ARB_RR_EN
        if (cpu_req && dma_req) begin
            winner = last_dma ? OWN_CPU : OWN_DMA;
        end else if (cpu_req) begin
            winner = OWN_CPU;
        end else if (dma_req) begin
            winner = OWN_DMA;
        end
`else
        if (dma_req && starve == SW'(STARVE_LIMIT)) begin
            winner = OWN_DMA;
        end else if (cpu_req) begin
            winner = OWN_CPU;
        end else if (dma_req) begin
            winner = OWN_DMA;
        end
`endif
    end

endmodule

// File: rtl/mem_arb.sv
// Serialises CPU and DMA accesses onto the single unified memory, inserting wait states
// and returning a one-cycle ack. Define MEM_ARB_RR_EN for round-robin arbitration.
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int WAIT_CYCLES  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic [DW-1:0] dma_rdata,
    output logic          dma_ack,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic [1:0]    grant
);

    localparam int CW = cnt_width(WAIT_CYCLES);

    state_t        state_q, state_d;
    owner_t        owner_q, owner_d;
    owner_t        winner;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] dma_rdata_q, dma_rdata_d;

`ifdef MEM_ARB_RR_EN
    logic last_dma_q, last_dma_d;

    arb_pick u_pick (
        .cpu_req  (cpu_req),
        .dma_req  (dma_req),
        .last_dma (last_dma_q),
        .winner   (winner)
    );
`else
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] starve_q, starve_d;

    arb_pick #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .SW           (SW)
    ) u_pick (
        .cpu_req (cpu_req),
        .dma_req (dma_req),
        .starve  (starve_q),
        .winner  (winner)
    );
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_NONE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dma_rdata_q <= '0;
`ifdef MEM_ARB_RR_EN
            last_dma_q  <= 1'b1;
`else
            starve_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dma_rdata_q <= dma_rdata_d;
`ifdef MEM_ARB_RR_EN
            last_dma_q  <= last_dma_d;
`else
            starve_q    <= starve_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dma_rdata_d = dma_rdata_q;
`ifdef MEM_ARB_RR_EN
        last_dma_d  = last_dma_q;
`else
        starve_d    = starve_q;
`endif
        case (state_q)
            IDLE: begin
                if (winner != OWN_NONE) begin
                    state_d = ACC;
                    owner_d = winner;
                    cnt_d   = CW'(WAIT_CYCLES - 1);
                    if (winner == OWN_CPU) begin
                        we_d    = cpu_we;
                        addr_d  = cpu_addr;
                        wdata_d = cpu_wdata;
                    end else begin
                        we_d    = dma_we;
                        addr_d  = dma_addr;
                        wdata_d = dma_wdata;
                    end
`ifdef MEM_ARB_RR_EN
                    last_dma_d = (winner == OWN_DMA);
`else
                    // A CPU win while the DMA also waits counts towards the forced DMA grant.
                    if (winner == OWN_DMA) begin
                        starve_d = '0;
                    end else if (dma_req && starve_q != SW'(STARVE_LIMIT)) begin
                        starve_d = starve_q + 1'b1;
                    end
`endif
                end
            end
            ACC: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                    if (!we_q) begin
                        if (owner_q == OWN_CPU) cpu_rdata_d = mem_rdata;
                        else                    dma_rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q != IDLE);
        grant   = busy ? owner_q : OWN_NONE;
        mem_we  = (state_q == ACC) && we_q && (cnt_q == '0);
        cpu_ack = (state_q == RESP) && (owner_q == OWN_CPU);
        dma_ack = (state_q == RESP) && (owner_q == OWN_DMA);
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_rdata = cpu_rdata_q;
    assign dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: two instances (WAIT_CYCLES 1 and 3) share stimulus and are checked
// every cycle against a transaction-timing model; directed scenarios pin literal values.
module tb_mem_arb;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int W0    = 1;
    localparam int W1    = 3;
    localparam int LIMIT = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0, dma_addr = '0;
    logic [DW-1:0] cpu_wdata = '0, dma_wdata = '0;

    logic [DW-1:0] cpu_rdata_o [2];
    logic [DW-1:0] dma_rdata_o [2];
    logic [AW-1:0] mem_addr_o  [2];
    logic [DW-1:0] mem_wdata_o [2];
    logic [DW-1:0] mem_rdata_i [2];
    logic [1:0]    grant_o     [2];
    logic [1:0]    cpu_ack_o, dma_ack_o, mem_we_o, busy_o;

    int total = 0;
    int bad   = 0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        if (a == 32'h10) return 32'hDEADBEEF;
        return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    assign mem_rdata_i[0] = memf(mem_addr_o[0]);
    assign mem_rdata_i[1] = memf(mem_addr_o[1]);

    mem_arb #(.AW(AW), .DW(DW), .WAIT_CYCLES(W0), .STARVE_LIMIT(LIMIT)) u_dut0 (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata_o[0]), .cpu_ack(cpu_ack_o[0]),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata_o[0]), .dma_ack(dma_ack_o[0]),
        .mem_addr(mem_addr_o[0]), .mem_wdata(mem_wdata_o[0]), .mem_we(mem_we_o[0]),
        .mem_rdata(mem_rdata_i[0]), .busy(busy_o[0]), .grant(grant_o[0])
    );

    mem_arb #(.AW(AW), .DW(DW), .WAIT_CYCLES(W1), .STARVE_LIMIT(LIMIT)) u_dut1 (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata_o[1]), .cpu_ack(cpu_ack_o[1]),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_rdata(dma_rdata_o[1]), .dma_ack(dma_ack_o[1]),
        .mem_addr(mem_addr_o[1]), .mem_wdata(mem_wdata_o[1]), .mem_we(mem_we_o[1]),
        .mem_rdata(mem_rdata_i[1]), .busy(busy_o[1]), .grant(grant_o[1])
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic got, input logic exp);
        chk(nm, {31'b0, got}, {31'b0, exp});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model: an access granted in IDLE cycle t0 occupies t0+1..t0+W (ACC), t0+W+1 (RESP).
    int          waitc [2] = '{W0, W1};
    bit          m_act [2];
    longint      m_t0  [2];
    logic [1:0]  m_own [2];
    bit          m_we  [2];
    logic [31:0] m_addr [2], m_wd [2], m_crd [2], m_drd [2];
    int          m_starve [2];
    bit          m_last_dma [2];
    longint      cyc = 0;
    longint      rel;
    bit          inacc, inresp;
    logic [1:0]  eg, w;

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                m_act[k] = 0; m_own[k] = 2'b00; m_we[k] = 0;
                m_addr[k] = '0; m_wd[k] = '0; m_crd[k] = '0; m_drd[k] = '0;
                m_starve[k] = 0; m_last_dma[k] = 1;
                chk1($sformatf("rst_busy%0d", k), busy_o[k], 1'b0);
                chk ($sformatf("rst_grant%0d", k), {30'b0, grant_o[k]}, 32'h0);
                chk1($sformatf("rst_mem_we%0d", k), mem_we_o[k], 1'b0);
                chk1($sformatf("rst_cpu_ack%0d", k), cpu_ack_o[k], 1'b0);
                chk1($sformatf("rst_dma_ack%0d", k), dma_ack_o[k], 1'b0);
                chk ($sformatf("rst_mem_addr%0d", k), mem_addr_o[k], 32'h0);
                chk ($sformatf("rst_mem_wdata%0d", k), mem_wdata_o[k], 32'h0);
                chk ($sformatf("rst_cpu_rdata%0d", k), cpu_rdata_o[k], 32'h0);
                chk ($sformatf("rst_dma_rdata%0d", k), dma_rdata_o[k], 32'h0);
            end else begin
                rel    = cyc - m_t0[k];
                inacc  = m_act[k] && rel >= 1 && rel <= waitc[k];
                inresp = m_act[k] && rel == waitc[k] + 1;
                eg     = (inacc || inresp) ? m_own[k] : 2'b00;
                chk ($sformatf("grant%0d", k), {30'b0, grant_o[k]}, {30'b0, eg});
                chk1($sformatf("busy%0d", k), busy_o[k], inacc || inresp);
                chk1($sformatf("mem_we%0d", k), mem_we_o[k], inacc && rel == waitc[k] && m_we[k]);
                chk1($sformatf("cpu_ack%0d", k), cpu_ack_o[k], inresp && m_own[k] == 2'b01);
                chk1($sformatf("dma_ack%0d", k), dma_ack_o[k], inresp && m_own[k] == 2'b10);
                chk ($sformatf("mem_addr%0d", k), mem_addr_o[k], m_addr[k]);
                chk ($sformatf("mem_wdata%0d", k), mem_wdata_o[k], m_wd[k]);
                chk ($sformatf("cpu_rdata%0d", k), cpu_rdata_o[k], m_crd[k]);
                chk ($sformatf("dma_rdata%0d", k), dma_rdata_o[k], m_drd[k]);
                if (inacc && rel == waitc[k] && !m_we[k]) begin
                    if (m_own[k] == 2'b01) m_crd[k] = memf(m_addr[k]);
                    else                   m_drd[k] = memf(m_addr[k]);
                end
                if (m_act[k]) begin
                    if (inresp) m_act[k] = 0;
                end else if (cpu_req || dma_req) begin
`ifdef MEM_ARB_RR_EN
                    if (cpu_req && dma_req) w = m_last_dma[k] ? 2'b01 : 2'b10;
                    else                    w = cpu_req ? 2'b01 : 2'b10;
                    m_last_dma[k] = (w == 2'b10);
`else
                    if (cpu_req && dma_req) begin
                        if (m_starve[k] == LIMIT) begin
                            w = 2'b10; m_starve[k] = 0;
                        end else begin
                            w = 2'b01;
                            m_starve[k] = (m_starve[k] + 1 > LIMIT) ? LIMIT : m_starve[k] + 1;
                        end
                    end else if (cpu_req) begin
                        w = 2'b01;
                    end else begin
                        w = 2'b10; m_starve[k] = 0;
                    end
`endif
                    m_own[k]  = w;
                    m_we[k]   = (w == 2'b01) ? cpu_we : dma_we;
                    m_addr[k] = (w == 2'b01) ? cpu_addr : dma_addr;
                    m_wd[k]   = (w == 2'b01) ? cpu_wdata : dma_wdata;
                    m_act[k]  = 1;
                    m_t0[k]   = cyc;
                end
            end
        end
        cyc++;
    end

    logic [1:0] seq [16];
    int         got;

    // Record grant owners of instance 0 as each new access begins.
    task automatic collect(input int want);
        logic [1:0] prevg;
        prevg = grant_o[0];
        got = 0;
        for (int c = 0; c < 300 && got < want; c++) begin
            step();
            chk1("ack_exclusive", cpu_ack_o[0] & dma_ack_o[0], 1'b0);
            if (grant_o[0] != 2'b00 && prevg == 2'b00) begin
                seq[got] = grant_o[0];
                got++;
            end
            prevg = grant_o[0];
        end
        chk("grant_count", got, want);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    int we_cnt [2], ack_cnt [2], busy_cnt [2];
`ifdef MEM_ARB_RR_EN
    localparam logic [1:0] EXP_RR [6] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
`else
    localparam logic [1:0] EXP_FP [10] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10,
                                           2'b01, 2'b01, 2'b01, 2'b01, 2'b10};
`endif

    initial begin
        #1 rst = 1'b0;
        repeat (3) step();
        #1 rst = 1'b1;

        // CPU read of 0x10 on the WAIT_CYCLES=1 instance
        cpu_we = 0; cpu_addr = 32'h10; cpu_req = 1;
        for (int n = 1; n <= 5; n++) begin
            step();
            chk1("t1_cpu_ack", cpu_ack_o[0], n == 2);
            chk1("t1_mem_we", mem_we_o[0], 1'b0);
            chk1("t1_dma_ack", dma_ack_o[0], 1'b0);
            if (n == 2) cpu_req = 0;
        end
        chk("t1_cpu_rdata", cpu_rdata_o[0], 32'hDEADBEEF);
        repeat (6) step();

        // DMA write on the WAIT_CYCLES=3 instance
        dma_we = 1; dma_addr = 32'h20; dma_wdata = 32'h12345678; dma_req = 1;
        for (int n = 1; n <= 6; n++) begin
            step();
            chk1("t2_mem_we", mem_we_o[1], n == 3);
            if (n == 3) begin
                chk("t2_mem_addr", mem_addr_o[1], 32'h20);
                chk("t2_mem_wdata", mem_wdata_o[1], 32'h12345678);
            end
            chk1("t2_dma_ack", dma_ack_o[1], n == 4);
            if (n == 4) dma_req = 0;
        end
        chk("t2_dma_rdata", dma_rdata_o[1], 32'h0);
        repeat (6) step();

        // Both requesters held continuously
        cpu_we = 0; dma_we = 0; cpu_addr = 32'h30; dma_addr = 32'h50;
        cpu_req = 1; dma_req = 1;
`ifdef MEM_ARB_RR_EN
        collect(6);
        for (int i = 0; i < 6; i++) chk($sformatf("t5_rr_grant[%0d]", i), {30'b0, seq[i]}, {30'b0, EXP_RR[i]});
        cpu_req = 0;
        repeat (12) step();
        dma_req = 0;
        repeat (8) step();
        dma_req = 1;
        collect(2);
        for (int i = 0; i < 2; i++) chk($sformatf("t5_dma_only[%0d]", i), {30'b0, seq[i]}, 32'h2);
        dma_req = 0;
`else
        collect(10);
        for (int i = 0; i < 10; i++) chk($sformatf("t3_fp_grant[%0d]", i), {30'b0, seq[i]}, {30'b0, EXP_FP[i]});
        cpu_req = 0; dma_req = 0;
`endif
        repeat (8) step();

        // Asynchronous reset in the second ACC cycle of a CPU write (WAIT_CYCLES=3)
        cpu_we = 1; cpu_addr = 32'h40; cpu_wdata = 32'hCAFE0001; cpu_req = 1;
        step();
        step();
        chk1("t4_busy_before", busy_o[1], 1'b1);
        #1 rst = 1'b0;
        #1;
        chk1("t4_mem_we", mem_we_o[1], 1'b0);
        chk ("t4_grant", {30'b0, grant_o[1]}, 32'h0);
        chk1("t4_busy", busy_o[1], 1'b0);
        chk1("t4_cpu_ack", cpu_ack_o[1], 1'b0);
        cpu_req = 0;
        step();
        #1 rst = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            step();
            chk1("t4_no_ack", cpu_ack_o[1], 1'b0);
        end
        cpu_we = 0; cpu_addr = 32'h10; cpu_req = 1;
        for (int n = 1; n <= 6; n++) begin
            step();
            chk1("t4_fresh_ack", cpu_ack_o[1], n == 4);
            if (n == 4) cpu_req = 0;
        end
        chk("t4_fresh_rdata", cpu_rdata_o[1], 32'hDEADBEEF);
        repeat (6) step();

        // CPU drops req in the first ACC cycle of a write
        cpu_we = 1; cpu_addr = 32'h80; cpu_wdata = 32'h0BADF00D; cpu_req = 1;
        for (int k = 0; k < 2; k++) begin we_cnt[k] = 0; ack_cnt[k] = 0; busy_cnt[k] = 0; end
        for (int n = 1; n <= 10; n++) begin
            step();
            if (n == 1) cpu_req = 0;
            for (int k = 0; k < 2; k++) begin
                we_cnt[k]   += int'(mem_we_o[k]);
                ack_cnt[k]  += int'(cpu_ack_o[k]);
                busy_cnt[k] += int'(busy_o[k]);
            end
        end
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("t6_we_pulses%0d", k), we_cnt[k], 1);
            chk($sformatf("t6_ack_pulses%0d", k), ack_cnt[k], 1);
            chk($sformatf("t6_busy_cycles%0d", k), busy_cnt[k], waitc[k] + 1);
        end

        // Randomised traffic, one mid-run reset
        for (int c = 0; c < 3000; c++) begin
            step();
            if (c == 1500) begin
                #1 rst = 1'b0;
                step();
                #1 rst = 1'b1;
            end
            if ($urandom_range(0, 3) == 0) begin
                cpu_req   = 1'($urandom_range(0, 1));
                cpu_we    = 1'($urandom_range(0, 1));
                cpu_addr  = 32'($urandom_range(0, 7)) << 4;
                cpu_wdata = $urandom;
            end
            if ($urandom_range(0, 3) == 0) begin
                dma_req   = 1'($urandom_range(0, 1));
                dma_we    = 1'($urandom_range(0, 1));
                dma_addr  = 32'($urandom_range(0, 7)) << 4;
                dma_wdata = $urandom;
            end
        end
        cpu_req = 0; dma_req = 0;
        repeat (10) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
